load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits directly downstream of the core's ALU/register-file outputs and upstream of a handshaked data memory.
Converts load/store requests (address, store data, funct3) into word-aligned memory transactions with byte enables.
Stalls the core until memory acknowledges, then returns sign- or zero-extended load data.
Detects misaligned and illegal-size accesses and memory timeouts, and reports them as faults.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles in BUSY waiting for mem_ack before a timeout fault (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ld_req  in  1  load requested; held by core while stall=1
st_req  in  1  store requested; held by core while stall=1
funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  core must hold PC and inputs
done  out  1  one-cycle pulse when an access completes (with or without fault)
rdata  out  32  extended load data, registered
fault  out  1  one-cycle pulse when an access is rejected or times out
fault_cause  out  2  01 misaligned, 10 illegal size, 11 timeout; valid with fault, else 00
mem_req  out  1  memory request, registered, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  32  word address, {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid when mem_ack=1
mem_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset (synchronous, active-high): state=IDLE, timeout counter=0. All outputs are 0, including rdata.
- States: IDLE, BUSY, DONE.
- Request priority: st_req wins if ld_req and st_req are both set; the access is a store.
- IDLE, with a request pending, checks the access:
  - Illegal funct3 (011, 110, 111; or 100/101 with st_req): fault=1, fault_cause=10, done=1, no mem_req, stay IDLE.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): fault=1, fault_cause=01, done=1, no mem_req, stay IDLE.
  - Otherwise: latch addr, wdata, funct3 and we, and go to BUSY.
  - Fault and done are combinational in IDLE; stall=0.
- BUSY:
  - mem_req=1 with stable mem_we, mem_addr, mem_be and mem_wdata.
  - On mem_ack: capture extended mem_rdata into rdata (loads only; stores leave rdata unchanged) and go to DONE.
  - The counter increments each BUSY cycle without ack. When the count reaches TIMEOUT_CYCLES: go to DONE with fault_cause=11 latched, drop mem_req, leave rdata unchanged.
  - An ack arriving in the same cycle as the timeout wins (no fault).
- DONE: done=1, plus fault=1 if a timeout was latched; stall=0, mem_req=0. Return to IDLE next cycle. Requests seen in DONE are ignored (they are the retiring instruction).
- stall = BUSY, or IDLE with a valid (non-faulting) request.
- Minimum latency: request in cycle 0, mem_req in cycle 1, ack in cycle 1, done in cycle 2.
- mem_ack outside BUSY is ignored.
- Reset in BUSY: mem_req drops at that edge and any later ack is ignored.
- Byte enables and store lanes:
  - SB: mem_be = 4'b0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = addr[1] ? 1100 : 0011, mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111, mem_wdata = wdata.
  - Loads: mem_be = 1111.
- Load extraction: select the byte by addr[1:0] or the half by addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.

Decomposition:
- Package lsu_pkg: state enum (IDLE, BUSY, DONE), funct3 size constants, fault cause constants.
- Sub-module load_extend: combinational (funct3, addr[1:0], mem_rdata) -> 32-bit extended data; instantiated once.
- The FSM, timeout counter and store-lane logic stay in load_store_unit.

Test Plan:
- LW addr 0x0000_0100, ack in the 3rd BUSY cycle with mem_rdata 0xDEAD_BEEF -> mem_req held 3 cycles, mem_addr 0x100, be 1111, done pulses, rdata 0xDEAD_BEEF, stall high for 4 cycles.
- LB / LBU addr 0x103, mem_rdata 0x80FF_1234 -> rdata 0xFFFF_FF80 / 0x0000_0080; LH addr 0x102 -> 0xFFFF_80FF.
- SH addr 0x102, wdata 0x0000_ABCD -> mem_we=1, mem_addr 0x100, mem_be 1100, mem_wdata 0xABCD_ABCD, rdata unchanged.
- LW addr 0x101 -> fault=1, fault_cause=01, done=1, stall=0, mem_req never asserted; funct3=011 -> fault_cause=10.
- TIMEOUT_CYCLES=4, no ack -> mem_req for exactly 4 cycles, then done=1, fault=1, fault_cause=11; a late ack is ignored.
- Reset asserted in the 2nd BUSY cycle -> next cycle mem_req=0, state IDLE, all outputs 0; ack during reset is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
// Contents: FSM state enum, funct3 access-size codes, fault cause codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects and extends the addressed byte/half of a load word
// Ports:
//   funct3_i    access size (B/H/W/BU/HU)
//   offset_i    byte offset within the word (addr[1:0])
//   mem_rdata_i raw word from memory
//   data_o      sign- or zero-extended load result
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_rdata_i[7:0];
        case (offset_i)
            2'd0:    byte_v = mem_rdata_i[7:0];
            2'd1:    byte_v = mem_rdata_i[15:8];
            2'd2:    byte_v = mem_rdata_i[23:16];
            default: byte_v = mem_rdata_i[31:24];
        endcase
        half_v = offset_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

        case (funct3_i)
            F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data_o = {24'b0, byte_v};
            F3_H:    data_o = {{16{half_v[15]}}, half_v};
            F3_HU:   data_o = {16'b0, half_v};
            default: data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - core-side load/store unit with handshaked data memory port
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ld_req, st_req        core requests (store wins), funct3 size, addr, wdata
//   stall, done, rdata    core handshake and extended load data
//   fault, fault_cause    access rejected (misaligned/illegal) or timed out
//   mem_*                 word-aligned memory request with byte enables, ack/rdata back
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_req,
    input  logic        st_req,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);

    lsu_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic        timeout_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;

    logic        is_store;
    logic        illegal;
    logic        misaligned;
    logic        idle_req;
    logic        idle_fault;
    logic        accept;
    logic [3:0]  be_d;
    logic [31:0] lanes_d;
    logic [CW-1:0] cnt_d;
    logic [31:0] load_data;

    always_comb begin
        is_store = st_req;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = is_store;   // no unsigned stores
            default:          illegal = 1'b1;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

        idle_req   = (state_q == IDLE) && (ld_req || st_req);
        idle_fault = idle_req && (illegal || misaligned);
        accept     = idle_req && !illegal && !misaligned;

        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr[1:0];
                lanes_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                lanes_d = {2{wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                lanes_d = wdata;
            end
        endcase
        if (!is_store) begin
            be_d = 4'b1111;
        end
        cnt_d = cnt_q + 1'b1;
    end

    load_extend u_load_extend (
        .funct3_i    (funct3_q),
        .offset_i    (offset_q),
        .mem_rdata_i (mem_rdata),
        .data_o      (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    cnt_q     <= '0;
                    if (accept) begin
                        state_q     <= BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store;
                        mem_addr_q  <= {addr[31:2], 2'b00};
                        mem_be_q    <= be_d;
                        mem_wdata_q <= lanes_d;
                        funct3_q    <= funct3;
                        offset_q    <= addr[1:0];
                    end
                end
                BUSY: begin
                    // ack is checked first so it wins over a same-cycle timeout
                    if (mem_ack) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        if (!mem_we_q) begin
                            rdata_q <= load_data;
                        end
                    end else if (cnt_d == TIMEOUT_LIMIT) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    // requests still present here belong to the retiring access
                    state_q   <= IDLE;
                    timeout_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall       = (state_q == BUSY) || accept;
    assign done        = (state_q == DONE) || idle_fault;
    assign fault       = ((state_q == DONE) && timeout_q) || idle_fault;
    assign fault_cause = idle_fault ? (illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN) :
                         ((state_q == DONE) && timeout_q) ? CAUSE_TIMEOUT : CAUSE_NONE;
    assign rdata       = rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int TO = 4;
    localparam int NV = 23;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req, st_req;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, fault;
    logic [31:0] rdata;
    logic [1:0]  fault_cause;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_req      (ld_req),
        .st_req      (st_req),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .done        (done),
        .rdata       (rdata),
        .fault       (fault),
        .fault_cause (fault_cause),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic [1:0]  cause;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] ext;
    } vec_t;

    vec_t        vecs [NV];
    vec_t        v;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_rdata;
    int          stall_cnt, req_cnt, done_cnt;
    logic        got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ld_req = 1'b0; st_req = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'b0, stall}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
        chk({tag, "_fault"}, {31'b0, fault}, 0);
        chk({tag, "_cause"}, {30'b0, fault_cause}, 0);
        chk({tag, "_mem_req"}, {31'b0, mem_req}, 0);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_be"}, {28'b0, mem_be}, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    initial begin
        //            ld    st    f3      addr          wdata         mrd           cause  be     mwd           ext
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 2'b00, 4'hF, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 2'b00, 4'hF, 32'h0,        32'h0000_0080};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 2'b00, 4'hF, 32'h0,        32'hFFFF_80FF};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_1234, 2'b00, 4'hF, 32'h0,        32'h0000_80FF};
        vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h80FF_1234, 2'b00, 4'hF, 32'h0,        32'h0000_0012};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h80FF_1234, 2'b00, 4'hF, 32'h0,        32'h0000_1234};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'h0BAD_F00D, 2'b00, 4'hF, 32'h0,        32'h0BAD_F00D};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 32'hFFFF_FFFF, 2'b00, 4'h2, 32'hA5A5_A5A5, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'hFFFF_FFFF, 2'b00, 4'hC, 32'hABCD_ABCD, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0200, 32'h1111_2222, 32'hFFFF_FFFF, 2'b00, 4'h3, 32'h2222_2222, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h0000_0208, 32'hCAFE_BABE, 32'hFFFF_FFFF, 2'b00, 4'hF, 32'hCAFE_BABE, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_010C, 32'h55AA_55AA, 32'hFFFF_FFFF, 2'b00, 4'hF, 32'h55AA_55AA, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         2'b01, 4'h0, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         2'b10, 4'h0, 32'h0,        32'h0};
        vecs[14] = '{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,         2'b10, 4'h0, 32'h0,        32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,         2'b01, 4'h0, 32'h0,        32'h0};
        vecs[16] = '{1'b1, 1'b0, 3'b101, 32'h0000_0101, 32'h0,        32'h0,         2'b01, 4'h0, 32'h0,        32'h0};
        vecs[17] = '{1'b1, 1'b0, 3'b110, 32'h0000_0100, 32'h0,        32'h0,         2'b10, 4'h0, 32'h0,        32'h0};
        vecs[18] = '{1'b0, 1'b1, 3'b111, 32'h0000_0100, 32'h0,        32'h0,         2'b10, 4'h0, 32'h0,        32'h0};
        vecs[19] = '{1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0,        32'h0,         2'b01, 4'h0, 32'h0,        32'h0};
        vecs[20] = '{1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0,        32'h0,         2'b01, 4'h0, 32'h0,        32'h0};
        vecs[21] = '{1'b1, 1'b0, 3'b100, 32'h0000_0100, 32'h0,        32'h0000_00F7, 2'b00, 4'hF, 32'h0,        32'h0000_00F7};
        vecs[22] = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_00F7, 2'b00, 4'hF, 32'h0,        32'hFFFF_FFF7};

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        model_rdata = '0;
        tick();

        // LW with ack in the third BUSY cycle
        ld_req = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
        stall_cnt = 0; req_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) idle_inputs();
            mem_ack   = (c == 3);
            mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (stall) stall_cnt++;
            if (mem_req) req_cnt++;
            if (done) done_cnt++;
            if (c == 1) begin
                chk("lw_mem_addr", mem_addr, 32'h0000_0100);
                chk("lw_mem_be", {28'b0, mem_be}, 32'hF);
                chk("lw_mem_we", {31'b0, mem_we}, 0);
            end
            if (c == 4) begin
                chk("lw_done", {31'b0, done}, 1);
                chk("lw_fault", {31'b0, fault}, 0);
                chk("lw_rdata", rdata, 32'hDEAD_BEEF);
            end
            tick();
        end
        model_rdata = 32'hDEAD_BEEF;
        chk("lw_stall_cycles", stall_cnt, 4);
        chk("lw_req_cycles", req_cnt, 3);
        chk("lw_done_pulses", done_cnt, 1);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            ld_req = v.ld; st_req = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
            #1;
            if (v.cause != 2'b00) begin
                chk($sformatf("v%0d_fault", i), {31'b0, fault}, 1);
                chk($sformatf("v%0d_cause", i), {30'b0, fault_cause}, {30'b0, v.cause});
                chk($sformatf("v%0d_done", i), {31'b0, done}, 1);
                chk($sformatf("v%0d_stall", i), {31'b0, stall}, 0);
                tick();
                idle_inputs();
                #1;
                chk($sformatf("v%0d_no_req", i), {31'b0, mem_req}, 0);
                chk($sformatf("v%0d_done_off", i), {31'b0, done}, 0);
                chk($sformatf("v%0d_rdata_kept", i), rdata, model_rdata);
            end else begin
                chk($sformatf("v%0d_fault0", i), {31'b0, fault}, 0);
                chk($sformatf("v%0d_stall_idle", i), {31'b0, stall}, 1);
                chk($sformatf("v%0d_req_idle", i), {31'b0, mem_req}, 0);
                tick();
                chk($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, 1);
                chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, v.st});
                chk($sformatf("v%0d_mem_addr", i), mem_addr, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d_mem_be", i), {28'b0, mem_be}, {28'b0, v.be});
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.mwd);
                mem_ack = 1'b1; mem_rdata = v.mrd;
                tick();
                mem_ack = 1'b0; mem_rdata = '0;
                #1;
                if (!v.st) model_rdata = v.ext;
                chk($sformatf("v%0d_done", i), {31'b0, done}, 1);
                chk($sformatf("v%0d_fault_done", i), {31'b0, fault}, 0);
                chk($sformatf("v%0d_stall_done", i), {31'b0, stall}, 0);
                chk($sformatf("v%0d_req_done", i), {31'b0, mem_req}, 0);
                chk($sformatf("v%0d_rdata", i), rdata, model_rdata);
                tick();
                idle_inputs();
            end
        end

        // timeout: no ack at all, then a late ack
        ld_req = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
        req_cnt = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (mem_req) req_cnt++;
            if (done) begin
                got = 1'b1;
                chk("to_fault", {31'b0, fault}, 1);
                chk("to_cause", {30'b0, fault_cause}, 32'h3);
                chk("to_stall", {31'b0, stall}, 0);
                chk("to_rdata", rdata, model_rdata);
                idle_inputs();
            end
            tick();
        end
        chk("to_done_seen", {31'b0, got}, 1);
        chk("to_req_cycles", req_cnt, TO);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("late_ack_done", {31'b0, done}, 0);
        chk("late_ack_req", {31'b0, mem_req}, 0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("late_ack_rdata", rdata, model_rdata);
        chk("late_ack_fault", {31'b0, fault}, 0);
        tick();

        // ack arriving in the same cycle as the timeout wins
        ld_req = 1'b1; funct3 = 3'b010; addr = 32'h0000_0304;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) idle_inputs();
            mem_ack   = (c == 4);
            mem_rdata = (c == 4) ? 32'h600D_CAFE : 32'h0;
            #1;
            if (c == 5) begin
                chk("race_done", {31'b0, done}, 1);
                chk("race_fault", {31'b0, fault}, 0);
                chk("race_cause", {30'b0, fault_cause}, 0);
                chk("race_rdata", rdata, 32'h600D_CAFE);
            end
            tick();
        end
        idle_inputs();
        tick();

        // reset during the second BUSY cycle, with an ack alongside it
        ld_req = 1'b1; funct3 = 3'b010; addr = 32'h0000_0400;
        tick();
        tick();
        #1;
        chk("rst_busy_req", {31'b0, mem_req}, 1);
        reset = 1'b1; ld_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        reset = 1'b0;
        #1;
        chk_all_zero("rst_busy");
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_ack_rdata", rdata, 0);
        chk("rst_ack_done", {31'b0, done}, 0);
        chk("rst_ack_req", {31'b0, mem_req}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
